// File: rtl/phold_pkg.sv
// -----------------------------------------------------------------------------
// phold_pkg
// Shared definitions for the PHOLD memory-controller path:
//   - MC command encodings
//   - MC return-control width
//   - per-core request struct
//   - helpers that pack/unpack {tag, core_id} into the MC return-control word
// -----------------------------------------------------------------------------
package phold_pkg;

   localparam int MC_RTNCTL_WIDTH = 32;

   localparam logic [2:0] MC_CMD_RD = 3'd1;
   localparam logic [2:0] MC_CMD_WR = 3'd2;

   // The tag field is kept at full return-control width so the pack helper can
   // take it directly; callers zero-extend their TAG_W-wide tag into it.
   typedef struct packed {
      logic [2:0]                 cmd;
      logic [3:0]                 scmd;
      logic [47:0]                vadr;
      logic [1:0]                 size;
      logic [63:0]                data;
      logic [MC_RTNCTL_WIDTH-1:0] tag;
   } mc_req_t;

   // rtnctl = {zeros, tag, core_id}; core_id occupies the low core_id_w bits.
   function automatic logic [MC_RTNCTL_WIDTH-1:0] rtnctl_pack(
      input logic [MC_RTNCTL_WIDTH-1:0] tag,
      input logic [MC_RTNCTL_WIDTH-1:0] core_id,
      input int                         core_id_w
   );
      return (tag << core_id_w) | core_id;
   endfunction

   function automatic logic [MC_RTNCTL_WIDTH-1:0] rtnctl_core(
      input logic [MC_RTNCTL_WIDTH-1:0] rtnctl,
      input int                         core_id_w
   );
      return rtnctl & ((MC_RTNCTL_WIDTH'(1) << core_id_w) - MC_RTNCTL_WIDTH'(1));
   endfunction

   function automatic logic [MC_RTNCTL_WIDTH-1:0] rtnctl_tag(
      input logic [MC_RTNCTL_WIDTH-1:0] rtnctl,
      input int                         core_id_w
   );
      return rtnctl >> core_id_w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Search starts at rr_ptr + 1; rr_ptr takes the granted
// index whenever a grant is actually issued (advance high and a request seen).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req   [N]   : request vector
//   advance     : downstream can accept; grants are suppressed when low
//   gnt   [N]   : one-hot grant (zero when advance is low)
//   idx   [IDX_W]: index of the selected request
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] rr_ptr_reg;
   logic [IDX_W-1:0] rr_ptr_next;
   logic [IDX_W-1:0] cand;
   logic [N-1:0]     pick;
   logic             found;

   // Walk N candidates starting just after the last winner; first hit wins.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDX_W'((int'(rr_ptr_reg) + k) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            idx       = cand;
            pick[cand] = 1'b1;
         end
      end
   end

   assign gnt         = advance ? pick : '0;
   assign rr_ptr_next = (advance && found) ? idx : rr_ptr_reg;

   // Reset to N-1 so index 0 has first priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_reg <= IDX_W'(N - 1);
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

endmodule

// File: rtl/mc_port_arbiter.sv
// -----------------------------------------------------------------------------
// mc_port_arbiter
// Shares one memory-controller port among NUM_CORES PHOLD cores.
//   - Round-robin grant of eligible core requests into a registered MC request
//     stage; the core ID travels in mc_rq_rtnctl[CORE_ID_W-1:0].
//   - Registered MC response stage routed back to the core named in rtnctl.
//   - Per-core outstanding-request counters gate eligibility.
//   - q_conf_cnt counts cycles with two or more eligible cores.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   core_rq_*  (in, packed) : per-core requests; core_rq_gnt (out) one-hot accept
//   core_rs_*  (out)        : response; vld one-hot, fields broadcast
//   core_rs_stall (in)      : per-core response backpressure
//   mc_rq_* (out), mc_rq_stall (in)   : MC request port
//   mc_rs_* (in),  mc_rs_stall (out)  : MC response port
//   q_conf_cnt (out)        : 64-bit arbitration-conflict counter
// -----------------------------------------------------------------------------
module mc_port_arbiter
   import phold_pkg::*;
#(
   parameter int NUM_CORES       = 8,
   parameter int CORE_ID_W       = 3,
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int TAG_W           = 8,
   parameter int MAX_OUTST       = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CORES-1:0]         core_rq_vld,
   input  logic [3*NUM_CORES-1:0]       core_rq_cmd,
   input  logic [4*NUM_CORES-1:0]       core_rq_scmd,
   input  logic [48*NUM_CORES-1:0]      core_rq_vadr,
   input  logic [2*NUM_CORES-1:0]       core_rq_size,
   input  logic [64*NUM_CORES-1:0]      core_rq_data,
   input  logic [TAG_W*NUM_CORES-1:0]   core_rq_tag,
   output logic [NUM_CORES-1:0]         core_rq_gnt,
   output logic [NUM_CORES-1:0]         core_rs_vld,
   output logic [2:0]                   core_rs_cmd,
   output logic [3:0]                   core_rs_scmd,
   output logic [TAG_W-1:0]             core_rs_tag,
   output logic [63:0]                  core_rs_data,
   input  logic [NUM_CORES-1:0]         core_rs_stall,
   output logic                         mc_rq_vld,
   output logic [2:0]                   mc_rq_cmd,
   output logic [3:0]                   mc_rq_scmd,
   output logic [47:0]                  mc_rq_vadr,
   output logic [1:0]                   mc_rq_size,
   output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
   output logic [63:0]                  mc_rq_data,
   output logic                         mc_rq_flush,
   input  logic                         mc_rq_stall,
   input  logic                         mc_rs_vld,
   input  logic [2:0]                   mc_rs_cmd,
   input  logic [3:0]                   mc_rs_scmd,
   input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
   input  logic [63:0]                  mc_rs_data,
   output logic                         mc_rs_stall,
   output logic [63:0]                  q_conf_cnt
);

   localparam int OUTST_W = $clog2(MAX_OUTST + 1);
   localparam int PKG_RW  = phold_pkg::MC_RTNCTL_WIDTH;

   logic [NUM_CORES-1:0]       eligible;
   logic [NUM_CORES-1:0]       gnt;
   logic [CORE_ID_W-1:0]       gnt_idx;
   logic                       can_load;
   mc_req_t                    sel_rq;

   logic                       rq_full_reg;
   mc_req_t                    rq_reg;
   logic [CORE_ID_W-1:0]       rq_id_reg;

   logic                       rs_full_reg;
   logic [2:0]                 rs_cmd_reg;
   logic [3:0]                 rs_scmd_reg;
   logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_reg;
   logic [63:0]                rs_data_reg;
   logic [CORE_ID_W-1:0]       rs_dst;
   logic                       rs_deliver;

   logic [63:0]                q_conf_cnt_reg;

   // ---------------- arbitration ----------------
   // Gating with rst_n keeps the combinational grant quiet while in reset.
   assign can_load = rst_n && (!rq_full_reg || !mc_rq_stall);

   rr_arbiter #(
      .N     (NUM_CORES),
      .IDX_W (CORE_ID_W)
   ) u_rr_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (eligible),
      .advance (can_load),
      .gnt     (gnt),
      .idx     (gnt_idx)
   );

   assign core_rq_gnt = gnt;

   always_comb begin
      sel_rq      = '0;
      sel_rq.cmd  = core_rq_cmd [int'(gnt_idx)*3  +: 3];
      sel_rq.scmd = core_rq_scmd[int'(gnt_idx)*4  +: 4];
      sel_rq.vadr = core_rq_vadr[int'(gnt_idx)*48 +: 48];
      sel_rq.size = core_rq_size[int'(gnt_idx)*2  +: 2];
      sel_rq.data = core_rq_data[int'(gnt_idx)*64 +: 64];
      sel_rq.tag  = PKG_RW'(core_rq_tag[int'(gnt_idx)*TAG_W +: TAG_W]);
   end

   // ---------------- request stage ----------------
   // Payload is only rewritten on a grant, so it holds through stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rq_full_reg <= 1'b0;
         rq_reg      <= '0;
         rq_id_reg   <= '0;
      end else if (can_load) begin
         rq_full_reg <= |gnt;
         if (|gnt) begin
            rq_reg    <= sel_rq;
            rq_id_reg <= gnt_idx;
         end
      end
   end

   assign mc_rq_vld    = rq_full_reg;
   assign mc_rq_cmd    = rq_reg.cmd;
   assign mc_rq_scmd   = rq_reg.scmd;
   assign mc_rq_vadr   = rq_reg.vadr;
   assign mc_rq_size   = rq_reg.size;
   assign mc_rq_data   = rq_reg.data;
   assign mc_rq_rtnctl = MC_RTNCTL_WIDTH'(rtnctl_pack(rq_reg.tag, PKG_RW'(rq_id_reg), CORE_ID_W));
   assign mc_rq_flush  = 1'b0;

   // ---------------- response stage ----------------
   assign rs_dst      = CORE_ID_W'(rtnctl_core(PKG_RW'(rs_rtnctl_reg), CORE_ID_W));
   assign rs_deliver  = rs_full_reg && !core_rs_stall[rs_dst];
   assign mc_rs_stall = rs_full_reg && core_rs_stall[rs_dst];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs_full_reg   <= 1'b0;
         rs_cmd_reg    <= '0;
         rs_scmd_reg   <= '0;
         rs_rtnctl_reg <= '0;
         rs_data_reg   <= '0;
      end else if (!mc_rs_stall) begin
         rs_full_reg <= mc_rs_vld;
         if (mc_rs_vld) begin
            rs_cmd_reg    <= mc_rs_cmd;
            rs_scmd_reg   <= mc_rs_scmd;
            rs_rtnctl_reg <= mc_rs_rtnctl;
            rs_data_reg   <= mc_rs_data;
         end
      end
   end

   assign core_rs_cmd  = rs_cmd_reg;
   assign core_rs_scmd = rs_scmd_reg;
   assign core_rs_data = rs_data_reg;
   assign core_rs_tag  = TAG_W'(rtnctl_tag(PKG_RW'(rs_rtnctl_reg), CORE_ID_W));

   // ---------------- per-core outstanding tracking ----------------
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [OUTST_W-1:0] outst_reg;
      logic               inc;
      logic               dec;

      assign inc = gnt[gi];
      assign dec = rs_deliver && (rs_dst == CORE_ID_W'(gi));

      assign eligible[gi]    = core_rq_vld[gi] && (outst_reg < OUTST_W'(MAX_OUTST));
      assign core_rs_vld[gi] = rs_full_reg && (rs_dst == CORE_ID_W'(gi));

      // Grant and delivery in the same cycle cancel out.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            outst_reg <= '0;
         end else if (inc && !dec) begin
            outst_reg <= outst_reg + OUTST_W'(1);
         end else if (dec && !inc) begin
            outst_reg <= outst_reg - OUTST_W'(1);
         end
      end
   end

   // ---------------- conflict counter ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_conf_cnt_reg <= '0;
      end else if ($countones(eligible) > 1) begin
         q_conf_cnt_reg <= q_conf_cnt_reg + 64'd1;
      end
   end

   assign q_conf_cnt = q_conf_cnt_reg;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mc_port_arbiter
// Directed stimulus with a scoreboard: expected MC requests and expected core
// responses are queued by the stimulus; a monitor pops and compares on every
// accepted mc_rq and every delivered core response.
// -----------------------------------------------------------------------------
module tb_mc_port_arbiter;
   import phold_pkg::*;

   localparam int N   = 8;
   localparam int IDW = 3;
   localparam int RW  = 32;
   localparam int TW  = 8;
   localparam int MO  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      core_rq_vld;
   logic [3*N-1:0]    core_rq_cmd;
   logic [4*N-1:0]    core_rq_scmd;
   logic [48*N-1:0]   core_rq_vadr;
   logic [2*N-1:0]    core_rq_size;
   logic [64*N-1:0]   core_rq_data;
   logic [TW*N-1:0]   core_rq_tag;
   logic [N-1:0]      core_rq_gnt;
   logic [N-1:0]      core_rs_vld;
   logic [2:0]        core_rs_cmd;
   logic [3:0]        core_rs_scmd;
   logic [TW-1:0]     core_rs_tag;
   logic [63:0]       core_rs_data;
   logic [N-1:0]      core_rs_stall;
   logic              mc_rq_vld;
   logic [2:0]        mc_rq_cmd;
   logic [3:0]        mc_rq_scmd;
   logic [47:0]       mc_rq_vadr;
   logic [1:0]        mc_rq_size;
   logic [RW-1:0]     mc_rq_rtnctl;
   logic [63:0]       mc_rq_data;
   logic              mc_rq_flush;
   logic              mc_rq_stall;
   logic              mc_rs_vld;
   logic [2:0]        mc_rs_cmd;
   logic [3:0]        mc_rs_scmd;
   logic [RW-1:0]     mc_rs_rtnctl;
   logic [63:0]       mc_rs_data;
   logic              mc_rs_stall;
   logic [63:0]       q_conf_cnt;

   always #5 clk = ~clk;

   mc_port_arbiter #(
      .NUM_CORES       (N),
      .CORE_ID_W       (IDW),
      .MC_RTNCTL_WIDTH (RW),
      .TAG_W           (TW),
      .MAX_OUTST       (MO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .core_rq_vld   (core_rq_vld),
      .core_rq_cmd   (core_rq_cmd),
      .core_rq_scmd  (core_rq_scmd),
      .core_rq_vadr  (core_rq_vadr),
      .core_rq_size  (core_rq_size),
      .core_rq_data  (core_rq_data),
      .core_rq_tag   (core_rq_tag),
      .core_rq_gnt   (core_rq_gnt),
      .core_rs_vld   (core_rs_vld),
      .core_rs_cmd   (core_rs_cmd),
      .core_rs_scmd  (core_rs_scmd),
      .core_rs_tag   (core_rs_tag),
      .core_rs_data  (core_rs_data),
      .core_rs_stall (core_rs_stall),
      .mc_rq_vld     (mc_rq_vld),
      .mc_rq_cmd     (mc_rq_cmd),
      .mc_rq_scmd    (mc_rq_scmd),
      .mc_rq_vadr    (mc_rq_vadr),
      .mc_rq_size    (mc_rq_size),
      .mc_rq_rtnctl  (mc_rq_rtnctl),
      .mc_rq_data    (mc_rq_data),
      .mc_rq_flush   (mc_rq_flush),
      .mc_rq_stall   (mc_rq_stall),
      .mc_rs_vld     (mc_rs_vld),
      .mc_rs_cmd     (mc_rs_cmd),
      .mc_rs_scmd    (mc_rs_scmd),
      .mc_rs_rtnctl  (mc_rs_rtnctl),
      .mc_rs_data    (mc_rs_data),
      .mc_rs_stall   (mc_rs_stall),
      .q_conf_cnt    (q_conf_cnt)
   );

   typedef struct {
      logic [47:0] vadr;
      logic [31:0] rtnctl;
      logic [63:0] data;
   } rq_exp_t;

   typedef struct {
      logic [7:0]  vld;
      logic [7:0]  tag;
      logic [63:0] data;
   } rs_exp_t;

   rq_exp_t rq_q[$];
   rs_exp_t rs_q[$];
   int      tests = 0;
   int      fails = 0;

   // Per-core request payload (fixed for the whole run).
   function automatic logic [47:0] vadr_of(input int i);
      return 48'h00AB_0000_0000 + 48'(i) * 48'h1000;
   endfunction
   function automatic logic [7:0] tag_of(input int i);
      return 8'h10 + 8'(i);
   endfunction
   function automatic logic [63:0] data_of(input int i);
      return 64'hDA7A_0000_0000_0000 | 64'(i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic push_rq(input int i);
      rq_exp_t e;
      e.vadr   = vadr_of(i);
      e.rtnctl = {21'b0, tag_of(i), 3'(i)};
      e.data   = data_of(i);
      rq_q.push_back(e);
   endtask

   task automatic push_rs(input logic [7:0] vld, input logic [7:0] tag, input logic [63:0] data);
      rs_exp_t e;
      e.vld  = vld;
      e.tag  = tag;
      e.data = data;
      rs_q.push_back(e);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n         = 1'b0;
      core_rq_vld   = '0;
      mc_rq_stall   = 1'b0;
      core_rs_stall = '0;
      mc_rs_vld     = 1'b0;
      repeat (2) step();
      rq_q.delete();
      rs_q.delete();
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      rq_exp_t qe;
      rs_exp_t se;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mc_rq_vld && !mc_rq_stall) begin
               if (rq_q.size() == 0) begin
                  check("mc_rq_unexpected", 64'(mc_rq_vld), 64'd0);
               end else begin
                  qe = rq_q.pop_front();
                  check("mc_rq_vadr",   64'(mc_rq_vadr),   64'(qe.vadr));
                  check("mc_rq_rtnctl", 64'(mc_rq_rtnctl), 64'(qe.rtnctl));
                  check("mc_rq_data",   mc_rq_data,        qe.data);
               end
            end
            if (|(core_rs_vld & ~core_rs_stall)) begin
               if (rs_q.size() == 0) begin
                  check("core_rs_unexpected", 64'(core_rs_vld), 64'd0);
               end else begin
                  se = rs_q.pop_front();
                  check("core_rs_vld",  64'(core_rs_vld), 64'(se.vld));
                  check("core_rs_tag",  64'(core_rs_tag), 64'(se.tag));
                  check("core_rs_data", core_rs_data,     se.data);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N; i++) begin
         core_rq_cmd [i*3  +: 3]  = MC_CMD_RD;
         core_rq_scmd[i*4  +: 4]  = 4'h0;
         core_rq_vadr[i*48 +: 48] = vadr_of(i);
         core_rq_size[i*2  +: 2]  = 2'd3;
         core_rq_data[i*64 +: 64] = data_of(i);
         core_rq_tag [i*TW +: TW] = tag_of(i);
      end
      mc_rs_cmd    = MC_CMD_RD;
      mc_rs_scmd   = 4'h0;
      mc_rs_rtnctl = '0;
      mc_rs_data   = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_mc_rq_vld",   64'(mc_rq_vld),   64'd0);
      check("rst_core_rs_vld", 64'(core_rs_vld), 64'd0);
      check("rst_mc_rs_stall", 64'(mc_rs_stall), 64'd0);
      check("rst_q_conf_cnt",  q_conf_cnt,       64'd0);
      check("rst_mc_rq_flush", 64'(mc_rq_flush), 64'd0);
      step();

      // Round-robin fairness: all cores valid, order 0..7,0
      core_rq_vld = '1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check($sformatf("rr_gnt_%0d", k), 64'(core_rq_gnt), 64'(1) << (k % 8));
         check($sformatf("rr_conf_%0d", k), q_conf_cnt, 64'(k));
         check($sformatf("rr_mc_vld_%0d", k), 64'(mc_rq_vld), 64'(k > 0));
         push_rq(k % 8);
         step();
      end
      core_rq_vld = '0;
      repeat (2) step();
      @(negedge clk);
      check("rr_conf_final", q_conf_cnt, 64'd9);
      step();

      // Request stall: core 3 in stage, stall 5 cycles, core 5 waits
      do_reset();
      core_rq_vld = 8'h08;
      @(negedge clk);
      check("stall_gnt_core3", 64'(core_rq_gnt), 64'h08);
      push_rq(3);
      step();
      core_rq_vld = 8'h20;
      mc_rq_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall_no_gnt_%0d", k), 64'(core_rq_gnt), 64'd0);
         check($sformatf("stall_vadr_%0d", k),   64'(mc_rq_vadr),  64'(vadr_of(3)));
         check($sformatf("stall_vld_%0d", k),    64'(mc_rq_vld),   64'd1);
         step();
      end
      mc_rq_stall = 1'b0;
      @(negedge clk);
      check("stall_release_gnt_core5", 64'(core_rq_gnt), 64'h20);
      push_rq(5);
      step();
      core_rq_vld = '0;
      step();

      // Response routing: two requests from core 6, then responses back
      core_rq_vld = 8'h40;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("rs_setup_gnt_%0d", k), 64'(core_rq_gnt), 64'h40);
         push_rq(6);
         step();
      end
      core_rq_vld  = '0;
      // rtnctl = {tag 0x2A, core 6} = (0x2A << 3) | 6
      mc_rs_vld    = 1'b1;
      mc_rs_rtnctl = 32'h0000_0156;
      mc_rs_data   = 64'h1111_2222_3333_4444;
      push_rs(8'h40, 8'h2A, 64'h1111_2222_3333_4444);
      @(negedge clk);
      check("rs_latency_not_yet", 64'(core_rs_vld), 64'd0);
      step();
      mc_rs_vld = 1'b0;
      @(negedge clk);
      check("rs_route_vld", 64'(core_rs_vld), 64'h40);
      check("rs_route_tag", 64'(core_rs_tag), 64'h2A);
      step();

      // Response backpressure on core 6: {tag 0x3B, core 6}
      core_rs_stall = 8'h40;
      mc_rs_vld     = 1'b1;
      mc_rs_rtnctl  = 32'h0000_01DE;
      mc_rs_data    = 64'hBEEF_0000_CAFE_0006;
      push_rs(8'h40, 8'h3B, 64'hBEEF_0000_CAFE_0006);
      @(negedge clk);
      check("bp_stage_empty", 64'(core_rs_vld), 64'd0);
      step();
      mc_rs_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp_mc_rs_stall_%0d", k), 64'(mc_rs_stall), 64'd1);
         check($sformatf("bp_data_hold_%0d", k),   core_rs_data,     64'hBEEF_0000_CAFE_0006);
         check($sformatf("bp_vld_hold_%0d", k),    64'(core_rs_vld), 64'h40);
         step();
      end
      core_rs_stall = '0;
      @(negedge clk);
      check("bp_release_stall", 64'(mc_rs_stall), 64'd0);
      step();
      @(negedge clk);
      check("bp_after_deliver", 64'(core_rs_vld), 64'd0);
      step();

      // Outstanding limit on core 2
      do_reset();
      core_rq_vld = 8'h04;
      for (int k = 0; k < MO; k++) begin
         @(negedge clk);
         check($sformatf("outst_gnt_%0d", k), 64'(core_rq_gnt), 64'h04);
         push_rq(2);
         step();
      end
      @(negedge clk);
      check("outst_limit_block", 64'(core_rq_gnt), 64'd0);
      step();
      // rtnctl = {tag 0x12, core 2} = 0x92
      mc_rs_vld    = 1'b1;
      mc_rs_rtnctl = 32'h0000_0092;
      mc_rs_data   = 64'h0000_0000_0000_0222;
      push_rs(8'h04, 8'h12, 64'h0000_0000_0000_0222);
      @(negedge clk);
      check("outst_block_rs_in", 64'(core_rq_gnt), 64'd0);
      step();
      mc_rs_vld = 1'b0;
      @(negedge clk);
      check("outst_block_delivering", 64'(core_rq_gnt), 64'd0);
      step();
      @(negedge clk);
      check("outst_regrant", 64'(core_rq_gnt), 64'h04);
      push_rq(2);
      step();
      core_rq_vld = '0;
      step();

      // Reset mid-operation with both stages full
      core_rq_vld   = 8'h01;
      mc_rq_stall   = 1'b1;
      mc_rs_vld     = 1'b1;
      mc_rs_rtnctl  = 32'h0000_0092;
      mc_rs_data    = 64'h0000_0000_0000_0444;
      core_rs_stall = 8'h04;
      @(negedge clk);
      check("mid_gnt_core0", 64'(core_rq_gnt), 64'h01);
      step();
      core_rq_vld = '0;
      mc_rs_vld   = 1'b0;
      @(negedge clk);
      check("mid_rq_full",  64'(mc_rq_vld),   64'd1);
      check("mid_rs_full",  64'(core_rs_vld), 64'h04);
      step();
      rst_n       = 1'b0;
      core_rq_vld = 8'h03;
      step();
      @(negedge clk);
      check("mid_rst_mc_rq_vld",    64'(mc_rq_vld),    64'd0);
      check("mid_rst_mc_rq_vadr",   64'(mc_rq_vadr),   64'd0);
      check("mid_rst_mc_rq_rtnctl", 64'(mc_rq_rtnctl), 64'd0);
      check("mid_rst_core_rs_vld",  64'(core_rs_vld),  64'd0);
      check("mid_rst_core_rs_data", core_rs_data,      64'd0);
      check("mid_rst_mc_rs_stall",  64'(mc_rs_stall),  64'd0);
      check("mid_rst_q_conf_cnt",   q_conf_cnt,        64'd0);
      check("mid_rst_gnt",          64'(core_rq_gnt),  64'd0);
      step();
      rst_n         = 1'b1;
      mc_rq_stall   = 1'b0;
      core_rs_stall = '0;
      rq_q.delete();
      rs_q.delete();
      @(negedge clk);
      check("mid_post_rst_gnt_core0", 64'(core_rq_gnt), 64'h01);
      push_rq(0);
      step();
      core_rq_vld = '0;
      repeat (3) step();

      check("drain_rq_queue", 64'(rq_q.size()), 64'd0);
      check("drain_rs_queue", 64'(rs_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
